// File: rtl/uart_tx_buf.sv
`default_nettype none
// ============================================================================
// uart_tx_buf : byte FIFO feeding a uart_tx serializer, one frame at a time,
//               with level/full/empty status, sticky overflow and watchdog.
// Revision 1.0 - initial release
// ============================================================================
module uart_tx_buf #(
    parameter int DEPTH_LOG2 = 4,
    parameter int TIMEOUT    = 200
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    input  logic                  flush,
    input  logic                  err_clr,
    input  logic                  tx_done_flag,
    output logic                  tx_start,
    output logic [7:0]            data_out,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  busy,
    output logic                  overflow,
    output logic                  timeout_err
);

    localparam int                  DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LVL_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [15:0]         WDOG_LAST  = 16'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  full_q, empty_q;
    logic [1:0]            state_q, state_d;
    logic [15:0]           wdog_q, wdog_d;
    logic                  start_q;
    logic [7:0]            data_q, data_d;
    logic                  busy_q;
    logic                  ovf_q, ovf_d;
    logic                  tmo_q, tmo_d;
    logic                  w_push, w_pop, w_tmo_set, w_drop;

    // Push and pop both look at pre-edge flags, so a pop never frees room for
    // a write on the same edge.
    assign w_push = wr_en && !full_q && !flush;
    assign w_drop = wr_en &&  full_q && !flush;
    assign w_pop  = (state_q == S_IDLE) && !empty_q && !flush;

    always_comb begin
        state_d   = state_q;
        wdog_d    = wdog_q;
        w_tmo_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_pop) state_d = S_START;
            end
            S_START: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (tx_done_flag) begin
                    state_d = S_IDLE;
                end else if (wdog_q == WDOG_LAST) begin
                    w_tmo_set = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (w_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
        end
    end

    always_comb begin
        data_d = w_pop ? mem_q[rd_ptr_q] : data_q;
        ovf_d  = w_drop    ? 1'b1 : (err_clr ? 1'b0 : ovf_q);
        tmo_d  = w_tmo_set ? 1'b1 : (err_clr ? 1'b0 : tmo_q);
    end

    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            state_q  <= S_IDLE;
            wdog_q   <= '0;
            start_q  <= 1'b0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= (level_d == FULL_LEVEL);
            empty_q  <= (level_d == '0);
            state_q  <= state_d;
            wdog_q   <= wdog_d;
            start_q  <= w_pop;
            data_q   <= data_d;
            busy_q   <= (state_d != S_IDLE);
            ovf_q    <= ovf_d;
            tmo_q    <= tmo_d;
        end
    end

    assign tx_start    = start_q;
    assign data_out    = data_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign level       = level_q;
    assign busy        = busy_q;
    assign overflow    = ovf_q;
    assign timeout_err = tmo_q;

endmodule
`default_nettype wire
